// File: rtl/hdmi_tx_config_seq.sv
// hdmi_tx_config_seq: ADV7511 power-up/hot-plug register-write sequencer driving an I2C req/ack master
module hdmi_tx_config_seq #(
  parameter int STARTUP_CYCLES = 2_500_000,
  parameter int GAP_CYCLES = 16,
  parameter int HPD_DEBOUNCE = 1024,
  parameter int MAX_RETRY = 3,
  parameter logic [7:0] DEV_ADDR = 8'h72
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       hpd,
  output logic       i2c_req,
  output logic [7:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_ack,
  input  logic       i2c_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       video_enable
);
  localparam int NUM_REGS = 11;
  localparam int PW = $clog2(STARTUP_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int DW = $clog2(HPD_DEBOUNCE + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int IW = $clog2(NUM_REGS + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(STARTUP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(HPD_DEBOUNCE - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REGS - 1);
  localparam logic [15:0] ROM [NUM_REGS] = '{
    16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
    16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'hAF04
  };
  typedef enum logic [2:0] {IDLE, WAIT_PWR, ISSUE, WAIT_ACK, GAP, DONE, ERROR} state_t;
  state_t state, state_n;
  logic hpd_s1, hpd_s2, hpd_db, hpd_db_q, unplug;
  logic hpd_rise, hpd_fall;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] pwr_cnt;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] retry;
  logic [IW-1:0] idx;
  assign hpd_rise = hpd_db & ~hpd_db_q;
  assign hpd_fall = ~hpd_db & hpd_db_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = (start | hpd_rise) ? WAIT_PWR : IDLE;
      WAIT_PWR: state_n = hpd_fall ? IDLE : pwr_cnt == PWR_LAST ? ISSUE : WAIT_PWR;
      ISSUE:    state_n = hpd_fall ? IDLE : WAIT_ACK;
      WAIT_ACK: state_n = !i2c_ack ? WAIT_ACK : (unplug | hpd_fall) ? IDLE :
                          i2c_nack ? (retry == RETRY_LAST ? ERROR : GAP) :
                          (idx == IDX_LAST ? DONE : GAP);
      GAP:      state_n = hpd_fall ? IDLE : gap_cnt == GAP_LAST ? ISSUE : GAP;
      DONE, ERROR: state_n = hpd_fall ? IDLE : start ? WAIT_PWR : state;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      hpd_s1 <= 1'b0;
      hpd_s2 <= 1'b0;
      hpd_db <= 1'b0;
      hpd_db_q <= 1'b0;
      unplug <= 1'b0;
      db_cnt <= '0;
      pwr_cnt <= '0;
      gap_cnt <= '0;
      retry <= '0;
      idx <= '0;
      i2c_req <= 1'b0;
      i2c_dev_addr <= '0;
      i2c_reg_addr <= '0;
      i2c_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      video_enable <= 1'b0;
    end else begin
      hpd_s1 <= hpd;
      hpd_s2 <= hpd_s1;
      hpd_db_q <= hpd_db;
      db_cnt <= (hpd_s2 == hpd_db || db_cnt == DB_LAST) ? '0 : db_cnt + 1'b1;
      if (hpd_s2 != hpd_db && db_cnt == DB_LAST) hpd_db <= hpd_s2;
      state <= state_n;
      pwr_cnt <= state == WAIT_PWR ? pwr_cnt + 1'b1 : '0;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      unplug <= state_n == WAIT_ACK && (unplug || hpd_fall);
      if (state == WAIT_PWR) begin
        idx <= '0;
        retry <= '0;
      end else if (state == WAIT_ACK && i2c_ack) begin
        if (i2c_nack) retry <= retry == RETRY_MAX ? retry : retry + 1'b1;
        else begin
          idx <= idx + 1'b1;
          retry <= '0;
        end
      end
      if (state == ISSUE) begin
        i2c_dev_addr <= DEV_ADDR;
        {i2c_reg_addr, i2c_wdata} <= ROM[idx];
      end
      i2c_req <= state_n == WAIT_ACK;
      busy <= !(state_n inside {IDLE, DONE, ERROR});
      done <= state_n == DONE;
      error <= state_n == ERROR;
      video_enable <= state_n == DONE;
    end
  end
endmodule
